// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock/step controller: switch modes, FSM
// states and the boundary decision taken at each CPU period edge.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  // Mode 2'b11 is an unused switch position and behaves like run.
  function automatic state_e boundary_next(input logic [1:0] mode,
                                           input logic       step_avail);
    state_e nxt;
    case (mode)
      MODE_HALT: nxt = IDLE;
      MODE_STEP: nxt = step_avail ? STEP : IDLE;
      default:   nxt = RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Reusable push-button conditioner: 2-FF synchroniser, stable-count
// debouncer and a one-cycle pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iIn,
  output logic oLevel,
  output logic oRisePulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= iIn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oLevel     = level_q;
  assign oRisePulse = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Processor clock generator with run/halt/single-step control, CPU cycle
// counter and a synchronised CPU reset. Mode changes act only at period edges.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_HALF   = 5,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [1:0]       iMode,
  input  logic             iStep,
  output logic             oCpuClk,
  output logic             oCpuRst_n,
  output logic             oRise,
  output logic [CNT_W-1:0] oCycles,
  output logic             oRunning
);

  localparam int PW = $clog2(2 * DIV_HALF);
  localparam logic [PW-1:0] P_LAST = PW'(2 * DIV_HALF - 1);
  localparam logic [PW-1:0] P_HIGH = PW'(DIV_HALF);

  logic [1:0]       mode_s1_q, mode_s2_q;
  logic             rst_s1_q, rst_s2_q;
  logic             step_level, step_pulse, step_req;
  logic             boundary, take;
  state_e           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             running_q, running_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
    .iClk      (iClk),
    .iRst      (iRst),
    .iIn       (iStep),
    .oLevel    (step_level),
    .oRisePulse(step_pulse)
  );

  // The pulse and the level update on the same edge; the level qualifies it.
  assign step_req = step_pulse & step_level;

  always_comb begin
    boundary  = (state_q == IDLE) || (p_q == P_LAST);
    take      = step_req && (state_q == IDLE);
    state_d   = boundary ? boundary_next(mode_s2_q, pending_q || take) : state_q;
    pending_d = pending_q;
    if (state_d == STEP)                 pending_d = 1'b0;
    else if (take && (state_d == IDLE))  pending_d = 1'b1;
    p_d       = ((state_q == IDLE) || (p_q == P_LAST)) ? '0 : p_q + 1'b1;
    clk_d     = (p_d >= P_HIGH);
    rise_d    = (p_d == P_HIGH);
    cycles_d  = cycles_q + CNT_W'(rise_d);
    running_d = (state_d != IDLE);
  end

  // NOTE: iRst clears every flop asynchronously, so a reset in the high phase drops oCpuClk at once.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mode_s1_q <= MODE_RUN;
      mode_s2_q <= MODE_RUN;
      state_q   <= IDLE;
      p_q       <= '0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      running_q <= 1'b0;
      pending_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      mode_s1_q <= iMode;
      mode_s2_q <= mode_s1_q;
      state_q   <= state_d;
      p_q       <= p_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      running_q <= running_d;
      pending_q <= pending_d;
      cycles_q  <= cycles_d;
    end
  end

  // Reset asserts with iRst and releases on the second clock edge afterwards.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= rst_s1_q;
    end
  end

  assign oCpuClk   = clk_q;
  assign oCpuRst_n = rst_s2_q;
  assign oRise     = rise_q;
  assign oCycles   = cycles_q;
  assign oRunning  = running_q;

endmodule
